cnn_layer_sequencer: RTL
========================

// Module: cnn_layer_sequencer
// PURPOSE
//  Upstream FSM driving the 8-bit ctrl code into the CNN layer controller: steps ctrl 1..6 (img load, conv1, pool1, conv2, pool2, FC).
//  Advances one layer each time that controller echoes the code back on return_ctrl, replacing per-layer software polling.
//  Software sees a start/busy/done/error interface. A per-layer watchdog flags hung layers.
// PARAMETERS
//  SETTLE_CYCLES   2        cycles after each ctrl change during which return_ctrl is ignored (lets stale *_done flags clear); 1..15
//  TIMEOUT_CYCLES  1048576  max cycles per layer 2..6 before error; 0 disables watchdog
//  CNT_W           32       width of layer cycle counter / perf_count
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  start        in   1      pulse: begin inference (IDLE or DONE only)
//  abort        in   1      return to IDLE from any state
//  img_ready    in   1      software finished writing image memory
//  return_ctrl  in   8      echo from layer controller
//  ctrl         out  8      layer code to layer controller
//  layer        out  3      current layer 0..6 (0 = idle/error)
//  busy         out  1      sequence in progress
//  done         out  1      FC finished, result valid
//  error        out  1      watchdog expired
//  perf_sel     in   3      layer select for perf_count (1..6)
//  perf_count   out  CNT_W  cycles spent in selected layer
// BEHAVIOUR
//  Reset: state IDLE; ctrl=0, layer=0, busy=0, done=0, error=0, all counters and perf registers 0. Reset beats every other input.
//  States: IDLE, SETTLE, WAIT, DONE, ERR. All outputs registered.
//  IDLE: ctrl=0. start=1 -> SETTLE with ctrl=1, layer=1, busy=1 next cycle.
//  SETTLE: settle counter loaded with SETTLE_CYCLES on entry; decrements each cycle. return_ctrl ignored. At 0 -> WAIT.
//  WAIT advance condition: 8-bit compare return_ctrl==ctrl; layer 1 also requires img_ready=1.
//  WAIT on advance, condition seen at cycle t:
//  - layer<6: ctrl=layer+1 at t+1, enter SETTLE.
//  - layer==6: enter DONE at t+1.
//  DONE: ctrl held at 6 so FC outputs stay valid; busy=0, done=1, layer=6.
//  - start -> SETTLE with ctrl=1, layer=1; done cleared same edge.
//  Layer cycle counter: cleared on each ctrl change; +1 per cycle in SETTLE/WAIT; saturates at all-ones.
//  Watchdog: applies to layers 2..6 only; layer 1 is software-paced.
//  - Counter reaching TIMEOUT_CYCLES in WAIT with no match -> ERR.
//  - Timeout and match in the same cycle: match wins.
//  ERR: ctrl=0, layer=0, busy=0, error=1. start ignored. Exit only by abort or reset.
//  abort=1 in any state -> IDLE next cycle: ctrl=0, layer=0, busy/done/error=0. abort beats start, match and timeout.
//  start while busy, or in ERR: ignored.
//  ctrl never takes values other than 0..6.
// CONFIGURATION
//  CNN_SEQ_PERF_CNT_EN defined:
//  - Six CNT_W perf registers, one per layer. Layer k register = cycles from first cycle ctrl=k through the match cycle inclusive.
//  - Written on advance; cleared on start.
//  - perf_count = register[perf_sel]; perf_sel 0 or 7 -> 0. Combinational read.
//  CNN_SEQ_PERF_CNT_EN undefined: ports present, perf_count tied 0, no perf registers.
// TESTING
//  1 Nominal: start at cyc 5; img_ready at cyc 20; model echoes ctrl 50 cyc after each change.
//    -> ctrl steps 1,2,3,4,5,6; done=1 one cyc after layer-6 match; busy=0; ctrl stays 6.
//  2 Settle: model echoes return_ctrl=k on the same edge ctrl becomes k, SETTLE_CYCLES=3.
//    -> ctrl does not advance until 4 cyc after the change.
//  3 Timeout: TIMEOUT_CYCLES=100; model never echoes 3.
//    -> error=1, ctrl=0 exactly when counter hits 100; start ignored; abort -> IDLE, error=0.
//  4 Abort: abort pulse while ctrl=4 -> next cyc ctrl=0, busy=0, done=0, layer=0; later start restarts at ctrl=1.
//  5 Reset mid-run: reset and start together during layer 5 -> all outputs reset values; no advance that cycle.
//  6 Perf (CNN_SEQ_PERF_CNT_EN): match on 50th cyc of each layer -> perf_count=50 for perf_sel 2..6.
//    -> perf_sel=0 gives 0; second start clears all perf registers.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Sequences the CNN layer controller through ctrl codes 1..6 (image load .. FC), advancing on each echo.
// Optional per-layer cycle counters are enabled with `define CNN_SEQ_PERF_CNT_EN.
module cnn_layer_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             img_ready_i,
  input  logic [7:0]       return_ctrl_i,
  output logic [7:0]       ctrl_o,
  output logic [2:0]       layer_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  input  logic [2:0]       perf_sel_i,
  output logic [CNT_W-1:0] perf_count_o
);

  localparam int unsigned SETTLE_W   = 4;
  localparam int unsigned NUM_LAYERS = 6;
  localparam logic [SETTLE_W-1:0] SETTLE_INIT  = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [CNT_W:0]      TIMEOUT_LAST = (CNT_W+1)'(TIMEOUT_CYCLES - 1);
  localparam bit                  WDOG_EN      = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          code_q, code_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                match, timeout;
  logic                perf_we, perf_clr;

  // Code 0..6 fits in 3 bits; layer number and ctrl code are the same value.
  assign ctrl_o  = {5'd0, code_q};
  assign layer_o = code_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign match   = (return_ctrl_i == {5'd0, code_q}) && ((code_q != 3'd1) || img_ready_i);
  // Layer 1 waits on software, so only layers 2..6 are watched.
  assign timeout = WDOG_EN && (code_q >= 3'd2) && ({1'b0, cnt_q} >= TIMEOUT_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      code_q   <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      settle_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    busy_d   = busy_q;
    done_d   = done_q;
    error_d  = error_q;
    settle_d = settle_q;
    perf_we  = 1'b0;
    perf_clr = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d  = S_SETTLE;
          code_d   = 3'd1;
          settle_d = SETTLE_INIT;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          perf_clr = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q <= SETTLE_W'(1)) begin
          state_d  = S_WAIT;
          settle_d = '0;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      S_WAIT: begin
        if (match) begin
          perf_we = 1'b1;
          if (code_q == 3'd6) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = S_SETTLE;
            code_d   = code_q + 3'd1;
            settle_d = SETTLE_INIT;
          end
        end else if (timeout) begin
          state_d = S_ERR;
          code_d  = 3'd0;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end
      end
      S_ERR: ;
      default: begin
        state_d = S_IDLE;
        code_d  = 3'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
      end
    endcase

    if (abort_i) begin
      state_d  = S_IDLE;
      code_d   = 3'd0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      perf_we  = 1'b0;
      perf_clr = 1'b0;
    end
  end

  // Layer cycle counter restarts on every ctrl change and runs only while a layer is active.
  always_comb begin
    cnt_d = cnt_q;
    if (code_d != code_q) begin
      cnt_d = '0;
    end else if ((state_q == S_SETTLE) || (state_q == S_WAIT)) begin
      cnt_d = cnt_inc;
    end
  end

`ifdef CNN_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] perf_q [NUM_LAYERS];

  // The match cycle itself is counted, hence cnt_inc rather than cnt_q.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (reset_i || perf_clr) begin
        perf_q[i] <= '0;
      end else if (perf_we && (code_q == 3'(i + 1))) begin
        perf_q[i] <= cnt_inc;
      end
    end
  end

  always_comb begin
    perf_count_o = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (perf_sel_i == 3'(i + 1)) begin
        perf_count_o = perf_q[i];
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf  = ^{perf_sel_i, perf_we, perf_clr, NUM_LAYERS[0]};
  assign perf_count_o = '0;
`endif

endmodule
